// File: rtl/id_ex_if.sv
// Decode-to-execute instruction bus with valid/ready handshake.
// The master drives the valid flag and the payload, and the slave drives ready.
interface id_ex_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REGADDR_W = 5,
    parameter int ALUOP_W   = 6
);
    logic                 valid;
    logic                 ready;
    logic [ALUOP_W-1:0]   aluop;
    logic [DATA_W-1:0]    reg1;
    logic [DATA_W-1:0]    reg2;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic                 ignore;
    logic [ADDR_W-1:0]    pc_store;
    logic [DATA_W-1:0]    imm;

    modport master (
        output valid, aluop, reg1, reg2, wd, wreg, ignore, pc_store, imm,
        input  ready
    );

    modport slave (
        input  valid, aluop, reg1, reg2, wd, wreg, ignore, pc_store, imm,
        output ready
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with valid/ready handshake, synchronous flush,
// an optional 2-entry skid buffer and a saturating stall counter.
module id_ex_pipe #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REGADDR_W   = 5,
    parameter int ALUOP_W     = 6,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    id_ex_if.slave                 id,
    id_ex_if.master                ex,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int PW = ALUOP_W + 3 * DATA_W + REGADDR_W + 2 + ADDR_W;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_reg;
    logic [PW-1:0] skid_reg;
    logic          main_valid;
    logic          main_wreg;
    logic          main_ignore;
    logic          accept;
    logic          retire;
    logic          load_main;
    logic          load_skid;
    logic          shift_skid;

    assign in_pl  = {id.aluop, id.reg1, id.reg2, id.wd, id.wreg, id.ignore, id.pc_store, id.imm};
    assign accept = id.valid & id.ready;
    assign retire = main_valid & ex.ready;

    generate
        if (SKID != 0) begin : g_skid
            // Encoding is {skid_valid, main_valid}.
            typedef enum logic [1:0] {
                EMPTY = 2'b00,
                ONE   = 2'b01,
                FULL  = 2'b11
            } state_t;

            state_t state_reg;
            state_t state_next;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg <= EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                if (flush) begin
                    state_next = EMPTY;
                end else begin
                    case (state_reg)
                        EMPTY: if (accept) state_next = ONE;
                        ONE: begin
                            if (accept && !retire)      state_next = FULL;
                            else if (retire && !accept) state_next = EMPTY;
                        end
                        FULL:    if (retire) state_next = ONE;
                        default: state_next = EMPTY;
                    endcase
                end
            end

            // A flush discards any same-cycle capture. The payload may go stale because the valid bits gate it.
            always_comb begin
                load_main  = 1'b0;
                load_skid  = 1'b0;
                shift_skid = 1'b0;
                if (!flush) begin
                    case (state_reg)
                        EMPTY: load_main = accept;
                        ONE: begin
                            load_main = accept & retire;
                            load_skid = accept & ~retire;
                        end
                        FULL:    shift_skid = retire;
                        default: ;
                    endcase
                end
            end

            assign main_valid = state_reg[0];
            assign id.ready   = ~state_reg[1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    skid_reg <= '0;
                end else if (load_skid) begin
                    skid_reg <= in_pl;
                end
            end
        end else begin : g_single
            logic main_valid_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_valid_reg <= 1'b0;
                end else if (flush) begin
                    main_valid_reg <= 1'b0;
                end else begin
                    main_valid_reg <= accept | (main_valid_reg & ~retire);
                end
            end

            assign main_valid = main_valid_reg;
            assign id.ready   = ~main_valid_reg | ex.ready;
            assign load_main  = accept & ~flush;
            assign load_skid  = 1'b0;
            assign shift_skid = 1'b0;
            assign skid_reg   = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_reg <= '0;
        end else if (load_main) begin
            main_reg <= in_pl;
        end else if (shift_skid) begin
            main_reg <= skid_reg;
        end
    end

    assign {ex.aluop, ex.reg1, ex.reg2, ex.wd, main_wreg, main_ignore, ex.pc_store, ex.imm} = main_reg;
    assign ex.valid  = main_valid;
    assign ex.wreg   = main_wreg & main_valid;
    assign ex.ignore = main_ignore & main_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !ex.ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench: dut0 is the skid build with a 4-bit stall counter, and dut1 is the single-stage build.
// The reference model treats each stage as a FIFO of held instructions with capacity 2 or 1.
module tb_id_ex_pipe;
    localparam int PW = 141;
    typedef logic [PW-1:0] pl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    id_ex_if id0 ();
    id_ex_if ex0 ();
    id_ex_if id1 ();
    id_ex_if ex1 ();
    logic [3:0]  stall0;
    logic [15:0] stall1;

    id_ex_pipe #(.SKID(1), .STALL_CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .id(id0), .ex(ex0), .stall_cnt(stall0)
    );
    id_ex_pipe #(.SKID(0), .STALL_CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .id(id1), .ex(ex1), .stall_cnt(stall1)
    );

    logic        vld_d[2];
    logic        rdy_d[2];
    pl_t         pl_d[2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic        out_wreg[2];
    logic        out_ignore[2];
    pl_t         out_pl[2];
    int unsigned out_stall[2];

    assign id0.valid = vld_d[0];
    assign {id0.aluop, id0.reg1, id0.reg2, id0.wd, id0.wreg, id0.ignore, id0.pc_store, id0.imm} = pl_d[0];
    assign ex0.ready = rdy_d[0];
    assign id1.valid = vld_d[1];
    assign {id1.aluop, id1.reg1, id1.reg2, id1.wd, id1.wreg, id1.ignore, id1.pc_store, id1.imm} = pl_d[1];
    assign ex1.ready = rdy_d[1];

    assign out_valid[0]  = ex0.valid;
    assign out_ready[0]  = id0.ready;
    assign out_wreg[0]   = ex0.wreg;
    assign out_ignore[0] = ex0.ignore;
    assign out_pl[0]     = {ex0.aluop, ex0.reg1, ex0.reg2, ex0.wd, ex0.wreg, ex0.ignore, ex0.pc_store, ex0.imm};
    assign out_stall[0]  = 32'(stall0);
    assign out_valid[1]  = ex1.valid;
    assign out_ready[1]  = id1.ready;
    assign out_wreg[1]   = ex1.wreg;
    assign out_ignore[1] = ex1.ignore;
    assign out_pl[1]     = {ex1.aluop, ex1.reg1, ex1.reg2, ex1.wd, ex1.wreg, ex1.ignore, ex1.pc_store, ex1.imm};
    assign out_stall[1]  = 32'(stall1);

    pl_t         exp_q[2][$];
    pl_t         src_q[2][$];
    int unsigned exp_stall[2];
    int unsigned stall_max[2] = '{15, 65535};
    int          tests = 0;
    int          fails = 0;
    bit          gap_en = 1'b0;

    task automatic chk(string name, int d, logic [159:0] act, logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h required %0h", name, d, act, exp);
        end
    endtask

    function automatic pl_t mk(logic [5:0] op);
        return {op, 32'($urandom), 32'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                32'($urandom), 32'($urandom)};
    endfunction

    // Decode side: the head of src_q is held until the stage takes it.
    task automatic present();
        for (int d = 0; d < 2; d++) begin
            vld_d[d] = (src_q[d].size() > 0) && !(gap_en && ($urandom_range(3) == 0));
            pl_d[d]  = (src_q[d].size() > 0) ? src_q[d][0] : mk(6'($urandom));
        end
    endtask

    task automatic settle();
        bit rdy_m[2];
        bit stl[2];
        for (int d = 0; d < 2; d++) begin
            rdy_m[d] = (d == 0) ? (exp_q[d].size() < 2) : (exp_q[d].size() == 0 || rdy_d[d]);
            stl[d]   = (exp_q[d].size() > 0) && !rdy_d[d];
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("id_ready", d, out_ready[d], rdy_m[d]);
            if (vld_d[d] && rdy_m[d]) void'(src_q[d].pop_front());
            if (flush) begin
                exp_q[d].delete();
                src_q[d].delete();
            end else if (vld_d[d] && rdy_m[d]) begin
                exp_q[d].push_back(pl_d[d]);
            end
            if (stl[d] && exp_stall[d] < stall_max[d]) exp_stall[d]++;
        end
        @(negedge clk);
    endtask

    task automatic step();
        present();
        settle();
    endtask

    task automatic set_rdy(bit r0, bit r1);
        rdy_d[0] = r0;
        rdy_d[1] = r1;
    endtask

    task automatic push_both(int op);
        src_q[0].push_back(mk(6'(op)));
        src_q[1].push_back(mk(6'(op)));
    endtask

    // Monitor: compares every presented instruction that EX consumes against the scoreboard.
    always @(negedge clk) begin
        pl_t e;
        #1;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                chk("stall_cnt", d, out_stall[d], exp_stall[d]);
                chk("ex_valid", d, out_valid[d], exp_q[d].size() > 0);
                if (!out_valid[d]) begin
                    chk("ex_wreg_gated", d, out_wreg[d], 0);
                    chk("ex_ignore_gated", d, out_ignore[d], 0);
                end else if (rdy_d[d] && exp_q[d].size() > 0) begin
                    e = exp_q[d].pop_front();
                    chk("payload", d, out_pl[d], e);
                    $display("[TB] dut%0d retire aluop=%0d wd=%0d", d, out_pl[d][140:135], out_pl[d][70:66]);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            vld_d[d] = 1'b0;
            rdy_d[d] = 1'b0;
            pl_d[d]  = '0;
            exp_stall[d] = 0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ex_valid", d, out_valid[d], 0);
            chk("reset_id_ready", d, out_ready[d], 1);
            chk("reset_stall", d, out_stall[d], 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Streaming with EX always ready.
        set_rdy(1, 1);
        for (int i = 1; i <= 4; i++) push_both(i);
        repeat (7) step();

        // Back-pressure, then release.
        set_rdy(0, 0);
        for (int i = 5; i <= 7; i++) push_both(i);
        repeat (4) step();
        set_rdy(1, 1);
        repeat (6) step();

        // Single-stage build: EX ready toggles 1,0,1.
        for (int i = 8; i <= 10; i++) push_both(i);
        for (int i = 0; i < 6; i++) begin
            set_rdy(1, i != 1);
            step();
        end

        // Flush while full, with an incoming instruction in the same cycle.
        set_rdy(0, 0);
        for (int i = 11; i <= 13; i++) push_both(i);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_rdy(1, 1);
        repeat (3) step();

        // Asynchronous reset mid-cycle while the skid build is full.
        set_rdy(0, 0);
        for (int i = 20; i <= 22; i++) push_both(i);
        repeat (3) step();
        #3 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ex_valid", d, out_valid[d], 0);
            chk("rst_ex_wreg", d, out_wreg[d], 0);
            chk("rst_ex_ignore", d, out_ignore[d], 0);
            chk("rst_stall", d, out_stall[d], 0);
            exp_q[d].delete();
            src_q[d].delete();
            exp_stall[d] = 0;
            vld_d[d] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) step();

        // Saturation of the 4-bit counter over a long stall.
        set_rdy(0, 0);
        push_both(30);
        repeat (21) step();
        chk("stall_saturate", 0, out_stall[0], 15);
        chk("stall_count", 1, out_stall[1], 20);
        set_rdy(1, 1);
        repeat (3) step();

        // Random traffic with gaps, back-pressure and occasional flushes.
        gap_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            set_rdy($urandom_range(3) != 0, $urandom_range(3) != 0);
            flush = ($urandom_range(31) == 0);
            for (int d = 0; d < 2; d++)
                if (src_q[d].size() < 3) src_q[d].push_back(mk(6'($urandom)));
            step();
        end
        flush = 1'b0;
        gap_en = 1'b0;
        set_rdy(1, 1);
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
Parametrised ID→EX pipeline register with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer. It replaces the plain always-load ID/EX latch.
- Decode can be back-pressured by multi-cycle EX ops (mul/div, memory waits) without losing instructions.
- Branch redirects can kill in-flight instructions.
- Stall cycles are counted for performance debug.

Parameters:
DATA_W, 32, width of reg1/reg2/imm operands
ADDR_W, 32, width of pc_store
REGADDR_W, 5, destination register address width
ALUOP_W, 6, ALU opcode width
SKID, 1, 1 = 2-entry skid buffer (registered id_ready); 0 = single stage (combinational id_ready)
STALL_CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
flush  in  1  kill all held instructions (sync)
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage can accept this cycle
id_aluop  in  ALUOP_W  ALU opcode
id_reg1  in  DATA_W  operand 1
id_reg2  in  DATA_W  operand 2
id_wd  in  REGADDR_W  destination reg
id_wreg  in  1  write-enable
id_ignore  in  1  ignore flag
id_pc_store  in  ADDR_W  pc to store (link)
id_imm  in  DATA_W  immediate
ex_valid  out  1  instruction presented to EX
ex_ready  in  1  EX consumes this cycle
ex_aluop, ex_reg1, ex_reg2, ex_wd, ex_pc_store, ex_imm  out  matching widths  payload to EX
ex_wreg  out  1  write-enable, gated: main_wreg & ex_valid
ex_ignore  out  1  ignore flag, gated: main_ignore & ex_valid
stall_cnt  out  STALL_CNT_W  cycles with ex_valid & !ex_ready, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - all payload regs, valid bits and stall_cnt go to 0; ex_valid=0, ex_wreg=0, ex_ignore=0.
  - id_ready=1 when SKID=1 (registered, reflects empty skid); SKID=0 also gives id_ready=1 because ex_valid=0.
- Handshakes: accept = id_valid & id_ready; retire = ex_valid & ex_ready. Payload is captured only on accept, never on idle cycles.
- SKID=0:
  - id_ready = !ex_valid | ex_ready.
  - On accept, main regs load next edge; main_valid <= accept | (main_valid & !retire).
  - Latency 1 cycle; full throughput.
- SKID=1, states by {skid_valid, main_valid}:
  - EMPTY: accept → main loads → ONE.
  - ONE: accept & retire → main reloads, stay ONE. Accept & !retire → skid loads → FULL. Retire & !accept → EMPTY.
  - FULL: id_ready=0. On retire, main <= skid, skid_valid <= 0 → ONE.
  - id_ready = !skid_valid (registered, no combinational path from ex_ready).
  - Latency 1 cycle; sustains 1 instr/cycle with ex_ready=1.
  - Instruction order strictly preserved.
- Flush (synchronous, highest priority):
  - next edge main_valid=0, skid_valid=0; any same-cycle accept is discarded.
  - Payload regs may keep stale values but gated ex_wreg/ex_ignore read 0.
  - id_ready is 1 the cycle after flush.
- Reset mid-operation: all held instructions dropped immediately (async); no retire occurs.
- stall_cnt:
  - +1 each cycle ex_valid & !ex_ready; holds at all-ones (no wrap).
  - Unaffected by flush; cleared only by reset.
- Outputs come straight from registers, except ex_wreg/ex_ignore (single AND gate) and id_ready when SKID=0.

Test Plan:
- Reset & idle: assert rst=0 mid-cycle with main/skid full → all ex_* outputs 0 immediately, stall_cnt=0, id_ready=1 after release.
- Streaming (SKID=1, ex_ready=1): issue 4 instrs, id_aluop 1..4 back-to-back → ex_aluop 1,2,3,4 on consecutive cycles, 1-cycle latency, id_ready stays 1.
- Back-pressure: ex_ready=0 while sending aluop 5,6,7 → 5 in main, 6 in skid, id_ready=0 so 7 is held by decode. Raise ex_ready → output order 5,6,7, nothing lost or duplicated. stall_cnt = number of stalled cycles.
- Flush: FULL state plus id_valid=1 and flush=1 in the same cycle → next cycle ex_valid=0, ex_wreg=0, id_ready=1; the flushed and incoming instrs never appear.
- Saturation: STALL_CNT_W=4, hold ex_valid=1, ex_ready=0 for 20 cycles → stall_cnt stops at 15.
- SKID=0 build: ex_ready toggling 1,0,1 → id_ready mirrors !ex_valid | ex_ready combinationally; order preserved.
